// File: rtl/clocking_drive_scheduler_if.sv
// clocking_drive_scheduler_if: requester, drive and sampler signals of the drive scheduler
interface clocking_drive_scheduler_if #(
    parameter int DW   = 8,
    parameter int DLYW = 3
);
    logic            req0_valid;
    logic            req0_ready;
    logic [DW-1:0]   req0_data;
    logic [DLYW-1:0] req0_delay;
    logic            req1_valid;
    logic            req1_ready;
    logic [DW-1:0]   req1_data;
    logic [DLYW-1:0] req1_delay;
    logic [DW-1:0]   drive_out;
    logic            drive_en;
    logic            conflict;
    logic            busy;
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   sampled_data;
    modport master (
        output req0_valid, req0_data, req0_delay, req1_valid, req1_data, req1_delay, in_data,
        input  req0_ready, req1_ready, drive_out, drive_en, conflict, busy, sampled_data
    );
    modport slave (
        input  req0_valid, req0_data, req0_delay, req1_valid, req1_data, req1_delay, in_data,
        output req0_ready, req1_ready, drive_out, drive_en, conflict, busy, sampled_data
    );
endinterface

// File: rtl/clocking_drive_scheduler.sv
// clocking_drive_scheduler: ##d drive calendar with two prioritised requesters and a skewed input sampler
module clocking_drive_scheduler #(
    parameter int DW         = 8,
    parameter int MAX_DELAY  = 7,
    parameter int INPUT_SKEW = 2,
    parameter int DLYW       = $clog2(MAX_DELAY + 1)
) (
    input logic                       clk,
    input logic                       rst,
    clocking_drive_scheduler_if.slave bus
);
    localparam int NSLOT = MAX_DELAY + 1;
    localparam int PW    = NSLOT > 1 ? $clog2(NSLOT) : 1;

    logic [PW-1:0]             ptr_q, ptr_d, t0, t1;
    logic [DLYW-1:0]           d0, d1;
    logic [NSLOT-1:0]          pend_q, pend_d;
    logic [NSLOT-1:0][DW-1:0]  data_q, data_d;
    logic [DW-1:0]             out_q, out_d;
    logic                      en_q, en_d, conf_q, conf_d, busy_q, acc1;
    logic [INPUT_SKEW-1:0][DW-1:0] pipe_q;

    always_comb begin
        d0 = bus.req0_delay > DLYW'(MAX_DELAY) ? DLYW'(MAX_DELAY) : bus.req0_delay;
        d1 = bus.req1_delay > DLYW'(MAX_DELAY) ? DLYW'(MAX_DELAY) : bus.req1_delay;
        t0 = PW'((int'(ptr_q) + int'(d0)) % NSLOT);
        t1 = PW'((int'(ptr_q) + int'(d1)) % NSLOT);
        acc1 = bus.req1_valid && !(bus.req0_valid && t0 == t1);
        pend_d = pend_q;
        data_d = data_q;
        conf_d = 1'b0;
        if (bus.req0_valid) begin
            conf_d    = pend_q[t0];
            pend_d[t0] = 1'b1;
            data_d[t0] = bus.req0_data;
        end
        if (acc1) begin
            conf_d     = conf_d | pend_q[t1];
            pend_d[t1] = 1'b1;
            data_d[t1] = bus.req1_data;
        end
        // retire sees this edge's writes, so d=0 drives immediately
        en_d = pend_d[ptr_q];
        out_d = en_d ? data_d[ptr_q] : out_q;
        pend_d[ptr_q] = 1'b0;
        ptr_d = ptr_q == PW'(NSLOT - 1) ? '0 : ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            pend_q <= '0;
            data_q <= '0;
            out_q  <= '0;
            en_q   <= 1'b0;
            conf_q <= 1'b0;
            busy_q <= 1'b0;
            pipe_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            pend_q <= pend_d;
            data_q <= data_d;
            out_q  <= out_d;
            en_q   <= en_d;
            conf_q <= conf_d;
            busy_q <= |pend_d;
            pipe_q[0] <= bus.in_data;
            for (int i = 1; i < INPUT_SKEW; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bus.req0_ready   = 1'b1;
    assign bus.req1_ready   = !(bus.req0_valid && t0 == t1);
    assign bus.drive_out    = out_q;
    assign bus.drive_en     = en_q;
    assign bus.conflict     = conf_q;
    assign bus.busy         = busy_q;
    assign bus.sampled_data = pipe_q[INPUT_SKEW-1];
endmodule

// File: tb/tb_clocking_drive_scheduler.sv
// tb_clocking_drive_scheduler: directed + random stimulus against an absolute-cycle calendar model
module tb_clocking_drive_scheduler;
    localparam int SKEW = 2;
    localparam int MAXD = 7;

    typedef struct {
        logic       en;
        logic [7:0] out;
        logic       conf;
        logic       busy;
        logic [7:0] samp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    exp_t q[$];
    logic [7:0] sched[int];
    logic [7:0] in_hist[int];
    logic [7:0] last_out;
    int cyc = 0;

    clocking_drive_scheduler_if #(.DW(8), .DLYW(3)) bus ();
    clocking_drive_scheduler #(.DW(8), .MAX_DELAY(MAXD), .INPUT_SKEW(SKEW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("drive_en", 32'(bus.drive_en), 32'(e.en));
            chk("drive_out", 32'(bus.drive_out), 32'(e.out));
            chk("conflict", 32'(bus.conflict), 32'(e.conf));
            chk("busy", 32'(bus.busy), 32'(e.busy));
            chk("sampled_data", 32'(bus.sampled_data), 32'(e.samp));
            chk("req0_ready", 32'(bus.req0_ready), 32'd1);
        end
    end

    // one cycle: drive inputs, predict the coming edge, push expectation, cross the edge
    task automatic step(input bit r, input bit v0, input int dl0, input logic [7:0] x0,
                        input bit v1, input int dl1, input logic [7:0] x1, input logic [7:0] din);
        exp_t e;
        int c0, c1;
        bit rdy1;
        rst = r;
        bus.req0_valid = v0; bus.req0_delay = 3'(dl0); bus.req0_data = x0;
        bus.req1_valid = v1; bus.req1_delay = 3'(dl1); bus.req1_data = x1;
        bus.in_data = din;
        #1;
        if (r) begin
            sched.delete();
            in_hist.delete();
            last_out = 8'h00;
            e = '{en: 1'b0, out: 8'h00, conf: 1'b0, busy: 1'b0, samp: 8'h00};
        end else begin
            c0 = dl0 > MAXD ? MAXD : dl0;
            c1 = dl1 > MAXD ? MAXD : dl1;
            rdy1 = !(v0 && c0 == c1);
            chk("req1_ready", 32'(bus.req1_ready), 32'(rdy1));
            e.conf = 1'b0;
            if (v0) begin
                if (sched.exists(cyc + c0)) e.conf = 1'b1;
                sched[cyc + c0] = x0;
            end
            if (v1 && rdy1) begin
                if (sched.exists(cyc + c1)) e.conf = 1'b1;
                sched[cyc + c1] = x1;
            end
            e.en = sched.exists(cyc);
            if (e.en) begin
                last_out = sched[cyc];
                sched.delete(cyc);
            end
            e.out = last_out;
            e.busy = sched.num() > 0;
            in_hist[cyc] = din;
            e.samp = in_hist.exists(cyc - SKEW + 1) ? in_hist[cyc - SKEW + 1] : 8'h00;
        end
        q.push_back(e);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 8'(cyc));
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 8'hA5, 0, 0, 0, 0);
        idle(5);
        step(0, 1, 2, 8'h11, 1, 2, 8'h22, 0);
        step(0, 0, 0, 0, 1, 2, 8'h22, 0);
        idle(4);
        step(0, 1, 4, 8'h01, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 8'h02, 0);
        idle(5);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        step(0, 1, 7, 8'h7E, 0, 0, 0, 0);
        step(0, 1, 0, 8'h55, 0, 0, 0, 0);
        idle(8);
        step(0, 1, 5, 8'h31, 1, 6, 8'h32, 0);
        step(0, 1, 5, 8'h33, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, MAXD), 8'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, MAXD), 8'($urandom),
                 8'($urandom));
        end
        idle(10);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
